axi_slave_protocol: RTL and testbench
=====================================

// Module: axi_slave_protocol
// PURPOSE
//  AXI4-Lite slave exposing a small bank of 32-bit registers on a 4-bit byte address
//  space. Independent write (AW/W/B) and read (AR/R) channels. Out-of-range register
//  indices return SLVERR. Serves as a protocol-compliant target for master VIP checks.
// PARAMETERS
//  NUM_REGS  3  number of implemented 32-bit registers; index = addr[3:2]; valid 0..NUM_REGS-1
// PORTS
//  clk      in   1   clock; all logic on rising edge
//  rst_n    in   1   reset, asynchronous, active-low
//  awaddr   in   4   write byte address
//  awvalid  in   1   write address valid
//  awready  out  1   write address ready
//  wdata    in   32  write data
//  wstrb    in   4   write byte strobes (bit i -> wdata[8i+7:8i])
//  wvalid   in   1   write data valid
//  wready   out  1   write data ready
//  bresp    out  2   write response: 2'b00 OKAY, 2'b10 SLVERR
//  bvalid   out  1   write response valid
//  bready   in   1   write response ready
//  araddr   in   4   read byte address
//  arvalid  in   1   read address valid
//  arready  out  1   read address ready
//  rdata    out  32  read data
//  rresp    out  2   read response: 2'b00 OKAY, 2'b10 SLVERR
//  rvalid   out  1   read data valid
//  rready   in   1   read data ready
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0; all registers 0x00000000.
//  Addressing: index = addr[3:2]; addr[1:0] ignored. index >= NUM_REGS -> SLVERR.
//  Write path:
//   - awready and wready are registered; driven high together for exactly one cycle when
//     awvalid && wvalid && !bvalid && !awready. Never asserted for AW or W alone.
//   - Handshake = posedge with awvalid&&awready&&wvalid&&wready. On it: if index valid,
//     update reg bytes where wstrb=1, bresp<=00; else no write, bresp<=10. bvalid<=1.
//   - bvalid/bresp held stable until posedge with bready=1, then bvalid<=0.
//   - No new AW/W accepted while bvalid=1 (one outstanding write).
//  Read path:
//   - arready driven high one cycle when arvalid && !rvalid && !arready.
//   - On arvalid&&arready: rdata<=reg[index] (or 0 if invalid), rresp<=00/10, rvalid<=1.
//   - rvalid/rdata/rresp held stable until posedge with rready=1, then rvalid<=0, rdata<=0.
//   - One outstanding read.
//  Latency: ready one cycle after valid seen; response valid the cycle after handshake.
//  Simultaneous read/write same register: read returns value before the write.
//  Valid held by master while ready low is tolerated indefinitely; ready never depends
//  combinationally on valid (all handshake outputs registered).
//  Reset mid-transaction: all handshakes abandoned, outputs return to 0 immediately.
// TESTING
//  1 Write 0x0 data 0xDEADBEEF wstrb F -> awready/wready 1-cycle pulse, bvalid, bresp=00.
//  2 Read 0x0 -> rvalid, rdata=0xDEADBEEF, rresp=00; rvalid drops after rready.
//  3 Write 0xC data 0xCAFEBABE -> bresp=10; read 0xC -> rresp=10, rdata=0; regs unchanged.
//  4 Write 0x4 0xFFFFFFFF then 0x4 0x00000000 wstrb 4'b0101 -> read 0x4 = 0xFF00FF00.
//  5 Hold bready=0 10 cycles -> bvalid/bresp stable, awready stays 0 with new awvalid.
//  6 Assert rst_n=0 during pending bvalid -> all outputs 0, read 0x0 afterwards = 0.

Source files
------------

// File: rtl/axi_slave_protocol.sv
// AXI4-Lite slave: a small bank of 32-bit registers on a 4-bit byte address space.
// The write (AW/W/B) and read (AR/R) channels are independent, and each allows one
// outstanding transaction. Every handshake output is registered, so no ready signal
// depends combinationally on a valid input.
module axi_slave_protocol #(
  parameter int NUM_REGS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  // AW and W are always accepted together, so a single flop drives both readies.
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  logic [1:0]  wr_idx, rd_idx;
  logic        wr_ok, rd_ok, wr_hs, rd_hs;
  logic [31:0] rd_val;

  // Next-state logic for both channels and for the register bank.
  always_comb begin
    regs_d    = regs_q;
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rd_val    = '0;

    wr_idx = awaddr[3:2];
    rd_idx = araddr[3:2];
    wr_ok  = (32'(wr_idx) < 32'(NUM_REGS));
    rd_ok  = (32'(rd_idx) < 32'(NUM_REGS));
    wr_hs  = awvalid && awready_q && wvalid && awready_q;
    rd_hs  = arvalid && arready_q;

    // Write channel: a one-cycle ready pulse, then a held response.
    awready_d = awvalid && wvalid && !bvalid_q && !awready_q;
    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && (int'(wr_idx) == i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) regs_d[i][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
    end

    // Read channel: the read samples regs_q, so a same-cycle write is not yet visible.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(rd_idx) == i) rd_val = regs_q[i];
    end
    arready_d = arvalid && !rvalid_q && !arready_q;
    if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
      rdata_d  = '0;
    end
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_val : 32'h0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // State registers; reset abandons any transaction in flight and clears the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = awready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_protocol.sv
// Testbench for axi_slave_protocol: directed scenarios, then randomized traffic
// scored against a behavioural register-bank model.
module tb_axi_slave_protocol;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: index 3 is never implemented, so its entry stays zero.
  logic [31:0] mdl [4];

  axi_slave_protocol #(.NUM_REGS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 32'(awready), 0);
    check({tag, "_wready"},  32'(wready),  0);
    check({tag, "_bvalid"},  32'(bvalid),  0);
    check({tag, "_bresp"},   32'(bresp),   0);
    check({tag, "_arready"}, 32'(arready), 0);
    check({tag, "_rvalid"},  32'(rvalid),  0);
    check({tag, "_rdata"},   rdata,        0);
    check({tag, "_rresp"},   32'(rresp),   0);
  endtask

  // Full write transaction; hold = cycles bready stays low, probe = offer a new write meanwhile.
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int hold, input bit probe);
    int n;
    logic ok;
    logic [1:0] eresp;
    ok    = (a[3:2] != 2'd3);
    eresp = ok ? 2'b00 : 2'b10;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 8);
    check("wr_ready_latency", n, 1);
    check("wr_wready", 32'(wready), 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_awready_pulse", 32'(awready), 0);
    check("wr_bvalid", 32'(bvalid), 1);
    check("wr_bresp", 32'(bresp), 32'(eresp));
    if (ok) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[3:2]][8*b +: 8] = d[8*b +: 8];
    end
    if (probe) begin awaddr = ~a; awvalid = 1'b1; wvalid = 1'b1; end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("wr_bvalid_hold", 32'(bvalid), 1);
      check("wr_bresp_hold", 32'(bresp), 32'(eresp));
      if (probe) begin
        check("wr_probe_awready", 32'(awready), 0);
        check("wr_probe_wready", 32'(wready), 0);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("wr_bvalid_drop", 32'(bvalid), 0);
  endtask

  // Full read transaction; expectation is taken from the model at entry.
  task automatic do_read(input logic [3:0] a, input int hold);
    int n;
    logic ok;
    logic [31:0] ed;
    ok = (a[3:2] != 2'd3);
    ed = ok ? mdl[a[3:2]] : 32'h0;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 8);
    check("rd_ready_latency", n, 1);
    check("rd_rvalid_early", 32'(rvalid), 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rd_arready_pulse", 32'(arready), 0);
    check("rd_rvalid", 32'(rvalid), 1);
    check("rd_rdata", rdata, ed);
    check("rd_rresp", 32'(rresp), ok ? 32'h0 : 32'h2);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("rd_rvalid_hold", 32'(rvalid), 1);
      check("rd_rdata_hold", rdata, ed);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rd_rvalid_drop", 32'(rvalid), 0);
    check("rd_rdata_clear", rdata, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    rst_n = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic write/read, out-of-range index, partial strobes, stalled response.
    do_write(4'h0, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    do_read(4'h0, 2);
    do_write(4'hC, 32'hCAFEBABE, 4'hF, 1, 1'b0);
    do_read(4'hC, 0);
    do_read(4'h0, 0);
    do_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    do_write(4'h4, 32'h00000000, 4'b0101, 0, 1'b0);
    do_read(4'h4, 0);
    check("strobe_merge", mdl[1], 32'hFF00FF00);
    do_write(4'h9, 32'h12345678, 4'hF, 10, 1'b1);
    do_read(4'hA, 1);

    // A read and a write to the same register in the same cycle return the old value.
    fork
      do_write(4'h8, 32'hA5A5A5A5, 4'hF, 0, 1'b0);
      do_read(4'h8, 0);
    join
    do_read(4'h8, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0: do_write(a, d, s, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        1: do_read(a, $urandom_range(0, 3));
        default: fork
          do_write(a, d, s, $urandom_range(0, 2), 1'b0);
          do_read(4'($urandom_range(0, 15)), $urandom_range(0, 2));
        join
      endcase
    end

    // Asynchronous reset while a write response is pending.
    awaddr = 4'h0; wdata = 32'h11223344; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_reset_bvalid", 32'(bvalid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(4'h0, 0);
    do_read(4'h4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
